// File: rtl/cmd_frame_sync_if.sv
// Byte-stream and control-unit signals shared between the UART side, the
// frame synchroniser and the command-field control unit.
interface cmd_frame_sync_if;
   logic [7:0] rx_data;
   logic       rx_int;
   logic       clear_int;
   logic       unlock;
   logic       valid_length;
   logic [7:0] frame_len;
   logic [7:0] cmd_val;
   logic       byte_int;
   logic [7:0] byte_data;
   logic       frame_done;
   logic       frame_err;
   logic [2:0] err_code;

   modport slave (
      input  rx_data, rx_int, clear_int, unlock,
      output valid_length, frame_len, cmd_val, byte_int, byte_data,
             frame_done, frame_err, err_code
   );

   modport master (
      output rx_data, rx_int, clear_int, unlock,
      input  valid_length, frame_len, cmd_val, byte_int, byte_data,
             frame_done, frame_err, err_code
   );
endinterface

// File: rtl/cmd_frame_sync.sv
// Frame synchroniser: SOF hunt, length check, payload forwarding with a sticky
// byte interrupt, EOF check and inter-byte timeout.
module cmd_frame_sync #(
   parameter logic [7:0] START_BYTE  = 8'hFE,
   parameter logic [7:0] END_BYTE    = 8'hEF,
   parameter int         MIN_LEN     = 1,
   parameter int         MAX_LEN     = 32,
   parameter int         TIMEOUT_CYC = 50000
) (
   input logic             clk,
   input logic             reset,
   cmd_frame_sync_if.slave bus
);
   localparam int            TW     = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TLIMIT = TW'(TIMEOUT_CYC - 1);
   localparam logic [TW-1:0] TONE   = TW'(1);
   localparam logic [7:0]    MIN_L  = 8'(MIN_LEN);
   localparam logic [7:0]    MAX_L  = 8'(MAX_LEN);

   typedef enum logic [2:0] {WAIT_SOF, GET_LEN, CHECK_LEN, FORWARD, GET_EOF} state_t;

   state_t        state_reg, state_next;
   logic [7:0]    frame_len_reg, frame_len_next;
   logic [7:0]    cmd_val_reg, cmd_val_next;
   logic [7:0]    byte_data_reg, byte_data_next;
   logic          byte_int_reg, byte_int_next;
   logic          valid_reg, valid_next;
   logic          done_reg, done_next;
   logic          err_reg, err_next;
   logic [2:0]    code_reg, code_next;
   logic [7:0]    bcnt_reg, bcnt_next;
   logic [TW-1:0] tcnt_reg, tcnt_next;
   logic          err_hit;
   logic [2:0]    err_val;
   logic          timed_out;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= WAIT_SOF;
         frame_len_reg <= '0;
         cmd_val_reg   <= '0;
         byte_data_reg <= '0;
         byte_int_reg  <= 1'b0;
         valid_reg     <= 1'b0;
         done_reg      <= 1'b0;
         err_reg       <= 1'b0;
         code_reg      <= '0;
         bcnt_reg      <= '0;
         tcnt_reg      <= '0;
      end else begin
         state_reg     <= state_next;
         frame_len_reg <= frame_len_next;
         cmd_val_reg   <= cmd_val_next;
         byte_data_reg <= byte_data_next;
         byte_int_reg  <= byte_int_next;
         valid_reg     <= valid_next;
         done_reg      <= done_next;
         err_reg       <= err_next;
         code_reg      <= code_next;
         bcnt_reg      <= bcnt_next;
         tcnt_reg      <= tcnt_next;
      end
   end

   assign timed_out = (tcnt_reg == TLIMIT);

   always_comb begin
      state_next     = state_reg;
      frame_len_next = frame_len_reg;
      cmd_val_next   = cmd_val_reg;
      byte_data_next = byte_data_reg;
      // Acknowledge is applied before any new byte in the same cycle.
      byte_int_next  = byte_int_reg & ~bus.clear_int;
      valid_next     = valid_reg;
      done_next      = 1'b0;
      err_next       = 1'b0;
      code_next      = code_reg;
      bcnt_next      = bcnt_reg;
      err_hit        = 1'b0;
      err_val        = 3'd0;
      if (state_reg == WAIT_SOF || bus.rx_int)
         tcnt_next = '0;
      else
         tcnt_next = tcnt_reg + TONE;

      case (state_reg)
         WAIT_SOF: begin
            if (bus.rx_int && bus.rx_data == START_BYTE && bus.unlock) begin
               state_next     = GET_LEN;
               code_next      = 3'd0;
               frame_len_next = '0;
               cmd_val_next   = '0;
            end
         end
         GET_LEN: begin
            if (bus.rx_int) begin
               frame_len_next = bus.rx_data;
               state_next     = CHECK_LEN;
            end else if (timed_out) begin
               err_hit = 1'b1;
               err_val = 3'd4;
            end
         end
         CHECK_LEN: begin
            if (bus.rx_int) begin
               err_hit = 1'b1;
               err_val = 3'd2;
            end else if (frame_len_reg >= MIN_L && frame_len_reg <= MAX_L) begin
               valid_next = 1'b1;
               bcnt_next  = '0;
               state_next = FORWARD;
            end else begin
               err_hit = 1'b1;
               err_val = 3'd1;
            end
         end
         FORWARD: begin
            if (bus.rx_int) begin
               if (byte_int_reg && !bus.clear_int) begin
                  err_hit = 1'b1;
                  err_val = 3'd2;
               end else begin
                  byte_data_next = bus.rx_data;
                  byte_int_next  = 1'b1;
                  bcnt_next      = bcnt_reg + 8'd1;
                  if (bcnt_reg == 8'd0)
                     cmd_val_next = bus.rx_data;
                  if ((bcnt_reg + 8'd1) == frame_len_reg)
                     state_next = GET_EOF;
               end
            end else if (timed_out) begin
               err_hit = 1'b1;
               err_val = 3'd4;
            end
         end
         GET_EOF: begin
            if (bus.rx_int) begin
               if (bus.rx_data == END_BYTE) begin
                  done_next  = 1'b1;
                  valid_next = 1'b0;
                  state_next = WAIT_SOF;
               end else begin
                  err_hit = 1'b1;
                  err_val = 3'd3;
               end
            end else if (timed_out) begin
               err_hit = 1'b1;
               err_val = 3'd4;
            end
         end
         default: state_next = WAIT_SOF;
      endcase

      if (err_hit) begin
         err_next      = 1'b1;
         code_next     = err_val;
         valid_next    = 1'b0;
         byte_int_next = 1'b0;
         state_next    = WAIT_SOF;
      end
   end

   always_comb begin
      bus.valid_length = valid_reg;
      bus.frame_len    = frame_len_reg;
      bus.cmd_val      = cmd_val_reg;
      bus.byte_int     = byte_int_reg;
      bus.byte_data    = byte_data_reg;
      bus.frame_done   = done_reg;
      bus.frame_err    = err_reg;
      bus.err_code     = code_reg;
   end
endmodule

// File: tb/tb_cmd_frame_sync.sv
// Directed bench for cmd_frame_sync: forwarded bytes go through a scoreboard
// queue; frame events are checked at fixed points after each byte.
module tb_cmd_frame_sync;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   cmd_frame_sync_if bus();

   cmd_frame_sync #(.TIMEOUT_CYC(100)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_assert = 0;
   int n_fail   = 0;
   logic [7:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One byte per call; fwd means the byte should appear on byte_data.
   task automatic send(input logic [7:0] b, input bit clr, input bit fwd);
      logic [7:0] e;
      @(posedge clk);
      #1;
      bus.rx_data   = b;
      bus.rx_int    = 1'b1;
      bus.clear_int = clr;
      if (fwd) exp_q.push_back(b);
      @(posedge clk);
      #1;
      bus.rx_int    = 1'b0;
      bus.clear_int = 1'b0;
      $display("rx %02h clr=%0d fwd=%0d -> byte_int=%0d byte_data=%02h valid=%0d done=%0d err=%0d code=%0d",
               b, clr, fwd, bus.byte_int, bus.byte_data, bus.valid_length,
               bus.frame_done, bus.frame_err, bus.err_code);
      if (fwd) begin
         e = exp_q.pop_front();
         chk("byte_data", bus.byte_data, e);
         chk("byte_int", bus.byte_int, 1);
      end
   endtask

   task automatic clr_pulse();
      @(posedge clk);
      #1;
      bus.clear_int = 1'b1;
      @(posedge clk);
      #1;
      bus.clear_int = 1'b0;
      chk("byte_int_cleared", bus.byte_int, 0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, bus.valid_length, 0);
      chk({tag, "_frame_len"}, bus.frame_len, 0);
      chk({tag, "_cmd_val"}, bus.cmd_val, 0);
      chk({tag, "_byte_int"}, bus.byte_int, 0);
      chk({tag, "_byte_data"}, bus.byte_data, 0);
      chk({tag, "_done"}, bus.frame_done, 0);
      chk({tag, "_err"}, bus.frame_err, 0);
      chk({tag, "_code"}, bus.err_code, 0);
   endtask

   initial begin
      int  n;
      bit  seen;
      bus.rx_data   = 8'h00;
      bus.rx_int    = 1'b0;
      bus.clear_int = 1'b0;
      bus.unlock    = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      reset = 1'b1;

      // Good frame FE 03 01 AA BB EF
      send(8'hFE, 0, 0);
      send(8'h03, 0, 0);
      chk("t1_frame_len", bus.frame_len, 8'h03);
      idle(1);
      chk("t1_valid", bus.valid_length, 1);
      send(8'h01, 0, 1);
      chk("t1_cmd_val", bus.cmd_val, 8'h01);
      clr_pulse();
      send(8'hAA, 0, 1);
      clr_pulse();
      send(8'hBB, 0, 1);
      clr_pulse();
      send(8'hEF, 0, 0);
      chk("t1_done", bus.frame_done, 1);
      chk("t1_err", bus.frame_err, 0);
      chk("t1_code", bus.err_code, 0);
      chk("t1_valid_drop", bus.valid_length, 0);
      idle(1);
      chk("t1_done_pulse", bus.frame_done, 0);

      // Length below minimum, then above maximum
      send(8'hFE, 0, 0);
      send(8'h00, 0, 0);
      idle(1);
      chk("t2_err_min", bus.frame_err, 1);
      chk("t2_code_min", bus.err_code, 1);
      chk("t2_valid_min", bus.valid_length, 0);
      idle(1);
      chk("t2_err_pulse", bus.frame_err, 0);
      send(8'hFE, 0, 0);
      chk("t2_code_cleared", bus.err_code, 0);
      send(8'h40, 0, 0);
      chk("t2_valid_chk", bus.valid_length, 0);
      idle(1);
      chk("t2_err_max", bus.frame_err, 1);
      chk("t2_code_max", bus.err_code, 1);
      chk("t2_valid_max", bus.valid_length, 0);

      // Overrun: second payload byte without acknowledge
      send(8'hFE, 0, 0);
      send(8'h02, 0, 0);
      send(8'h05, 0, 1);
      send(8'h06, 0, 0);
      chk("t3_err", bus.frame_err, 1);
      chk("t3_code", bus.err_code, 2);
      chk("t3_byte_int", bus.byte_int, 0);
      chk("t3_valid", bus.valid_length, 0);

      // Acknowledge coincident with the next byte: no overrun
      send(8'hFE, 0, 0);
      send(8'h02, 0, 0);
      send(8'h05, 0, 1);
      send(8'h06, 1, 1);
      chk("t3b_err", bus.frame_err, 0);
      chk("t3b_code", bus.err_code, 0);
      chk("t3b_valid", bus.valid_length, 1);
      clr_pulse();
      send(8'hEF, 0, 0);
      chk("t3b_done", bus.frame_done, 1);

      // Bad end-of-frame byte
      send(8'hFE, 0, 0);
      send(8'h01, 0, 0);
      send(8'h07, 0, 1);
      send(8'h55, 0, 0);
      chk("t4_err", bus.frame_err, 1);
      chk("t4_code", bus.err_code, 3);
      chk("t4_byte_int", bus.byte_int, 0);
      idle(5);
      chk("t4_cmd_held", bus.cmd_val, 8'h07);
      chk("t4_code_held", bus.err_code, 3);

      // Inter-byte timeout
      send(8'hFE, 0, 0);
      send(8'h04, 0, 0);
      send(8'h09, 0, 1);
      n = 0;
      seen = 1'b0;
      while (!seen && n < 200) begin
         @(posedge clk);
         #1;
         n++;
         if (bus.frame_err) seen = 1'b1;
      end
      chk("t5_seen", seen, 1);
      chk("t5_cycles", n, 100);
      chk("t5_code", bus.err_code, 4);
      chk("t5_valid", bus.valid_length, 0);

      // Locked control unit: whole frame must be ignored
      bus.unlock = 1'b0;
      send(8'hFE, 0, 0);
      send(8'h01, 0, 0);
      send(8'h02, 0, 0);
      send(8'hEF, 0, 0);
      chk("t6_valid", bus.valid_length, 0);
      chk("t6_done", bus.frame_done, 0);
      chk("t6_code_held", bus.err_code, 4);
      bus.unlock = 1'b1;

      // Reset in the middle of FORWARD, then garbage and a clean frame
      send(8'hFE, 0, 0);
      send(8'h03, 0, 0);
      send(8'h01, 0, 1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk_all_zero("t7_reset");
      @(posedge clk);
      #1;
      reset = 1'b1;
      send(8'h11, 0, 0);
      send(8'h22, 0, 0);
      chk("t7_garbage_valid", bus.valid_length, 0);
      send(8'hFE, 0, 0);
      send(8'h01, 0, 0);
      send(8'h02, 0, 1);
      chk("t7_cmd_val", bus.cmd_val, 8'h02);
      send(8'hEF, 0, 0);
      chk("t7_done", bus.frame_done, 1);
      chk("t7_code", bus.err_code, 0);

      chk("sb_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/cmd_frame_sync.md
Name: cmd_frame_sync

Overview:
- Byte-level frame synchroniser between the UART receiver and the command-field control unit.
- Hunts for a start-of-frame byte, captures and range-checks the length byte, then forwards each payload byte with a sticky byte interrupt.
- The control unit acknowledges each forwarded byte with its clear strobe.
- Checks the end-of-frame byte and an inter-byte timeout; reports errors with a one-cycle pulse and a held code.

Parameters:
- START_BYTE, 8'hFE, start-of-frame marker.
- END_BYTE, 8'hEF, end-of-frame marker.
- MIN_LEN, 1, smallest legal payload length in bytes (includes command byte).
- MAX_LEN, 32, largest legal payload length in bytes (MIN_LEN<=MAX_LEN<=255).
- TIMEOUT_CYC, 50000, idle cycles allowed between bytes inside a frame (>=2).

Ports:
- clk  in  1  single system clock, all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  byte from UART receiver, valid when rx_int=1.
- rx_int  in  1  one-cycle pulse per received byte.
- clear_int  in  1  control-unit acknowledge of forwarded byte (its clear flag).
- unlock  in  1  control unit idle and ready for a new frame (its unlock flag).
- valid_length  out  1  level: legal length accepted, frame in progress.
- frame_len  out  8  latched length byte.
- cmd_val  out  8  first payload byte (command), latched.
- byte_int  out  1  sticky: forwarded byte pending.
- byte_data  out  8  forwarded payload byte.
- frame_done  out  1  one-cycle pulse on correct end-of-frame.
- frame_err  out  1  one-cycle pulse on any error.
- err_code  out  3  0 none, 1 length, 2 overrun, 3 bad EOF, 4 timeout; held.

Behaviour:
- Reset: state WAIT_SOF, all outputs 0, byte counter 0, timeout counter 0.
- States: WAIT_SOF, GET_LEN, CHECK_LEN, FORWARD, GET_EOF.
- WAIT_SOF:
  - rx_int && rx_data==START_BYTE && unlock: go to GET_LEN, clear err_code to 0.
  - Any other byte is ignored; no error.
- GET_LEN: on rx_int, latch frame_len<=rx_data, go to CHECK_LEN.
- CHECK_LEN (exactly 1 cycle):
  - MIN_LEN<=frame_len<=MAX_LEN: set valid_length=1, clear byte counter, go to FORWARD.
  - Otherwise: frame_err pulse, err_code=1, go to WAIT_SOF.
  - An rx_int arriving in this cycle is dropped and counted as overrun (err_code=2, go to WAIT_SOF).
- FORWARD, on rx_int:
  - byte_data<=rx_data, byte_int<=1 (visible next cycle); counter increments.
  - Counter==0 (first byte): cmd_val<=rx_data.
  - Counter reaches frame_len: go to GET_EOF.
- byte_int clears on clear_int.
  - Same-cycle clear_int and rx_int: the clear applies first, so byte_int stays 1 with the new data and no overrun is flagged.
  - rx_int while byte_int=1 and clear_int=0: overrun, err_code=2.
- GET_EOF, on rx_int:
  - rx_data==END_BYTE: frame_done pulse, valid_length<=0, go to WAIT_SOF.
  - Otherwise: err_code=3.
- valid_length is held from CHECK_LEN pass until frame_done, any error, or reset.
  - cmd_val and frame_len are held until the next accepted START_BYTE.
- Timeout:
  - Applies in GET_LEN, FORWARD and GET_EOF.
  - Counter clears on every rx_int and increments otherwise.
  - Reaching TIMEOUT_CYC raises err_code=4.
- Any error, same cycle:
  - frame_err pulse; valid_length<=0, byte_int<=0; go to WAIT_SOF.
  - err_code is held until the next accepted START_BYTE.
- unlock=0 in WAIT_SOF blocks start detection; START_BYTE bytes received then are discarded.
- Reset mid-frame: immediate return to reset values; partial frame discarded.
- Counter width: 8 bits; frame_len<=255, so no wrap.

Test Plan:
- Frame FE 03 01 AA BB EF, clear_int 2 cycles after each byte_int:
  - valid_length=1 after CHECK_LEN; cmd_val=01.
  - byte_data sequence 01, AA, BB, each with byte_int.
  - frame_done pulse on EF; err_code=0.
- FE 00 (MIN_LEN=1), then FE 40 (MAX_LEN=32):
  - Each gives a frame_err pulse with err_code=1.
  - valid_length never rises; state returns to WAIT_SOF.
- FE 02 05, second payload byte sent with no clear_int:
  - Second byte gives frame_err with err_code=2; byte_int=0 next cycle.
  - Repeat with clear_int coincident with the second rx_int: no error, byte_data=second byte.
- FE 01 07 55: frame_err with err_code=3; cmd_val remains 07 until the next START_BYTE.
- FE 04 09 then silence (TIMEOUT_CYC=100):
  - frame_err with err_code=4 exactly 100 cycles after the last rx_int.
  - valid_length=0.
- Mid-FORWARD reset low for 1 cycle:
  - All outputs 0 immediately.
  - A following FE 01 02 EF completes normally with cmd_val=02.
  - Garbage bytes 11 22 before FE are ignored.
